// File: rtl/ext_mem_arbiter_pkg.sv
// Shared types for the external memory arbiter.
//   NUM_REQ        : number of requesters per channel (fixed at 2)
//   TAG_DATA_WIDTH : width of the forwarded-data field in the return tag;
//                    must be kept equal to the arbiter's DATA_WIDTH
//   req_id_t       : 1-bit requester id, also used as the round-robin pointer
//   ret_tag_t      : registered read-return tag {valid, id, fwd, fwd_data}
package ext_mem_arbiter_pkg;

  localparam int unsigned NUM_REQ        = 2;
  localparam int unsigned TAG_DATA_WIDTH = 32;

  typedef enum logic {
    REQ_0 = 1'b0,
    REQ_1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic                      valid;
    req_id_t                   id;
    logic                      fwd;
    logic [TAG_DATA_WIDTH-1:0] fwd_data;
  } ret_tag_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_0) ? REQ_1 : REQ_0;
  endfunction

endpackage

// File: rtl/ext_mem_arbiter_if.sv
// Requester-side bus of the external memory arbiter (two requesters).
//   rd_req_i / rd_addr_i            : read request and address (requester -> arbiter)
//   rd_gnt_i / rd_valid_i / rd_data_i : read grant, return valid, return data
//   wr_req_i / wr_addr_i / wr_data_i : write request, address, data
//   wr_gnt_i                         : write grant
// Modports: slave = arbiter side, master = requester side.
interface ext_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  rd_req_0;
  logic [ADDR_WIDTH-1:0] rd_addr_0;
  logic                  rd_gnt_0;
  logic                  rd_valid_0;
  logic [DATA_WIDTH-1:0] rd_data_0;
  logic                  rd_req_1;
  logic [ADDR_WIDTH-1:0] rd_addr_1;
  logic                  rd_gnt_1;
  logic                  rd_valid_1;
  logic [DATA_WIDTH-1:0] rd_data_1;

  logic                  wr_req_0;
  logic [ADDR_WIDTH-1:0] wr_addr_0;
  logic [DATA_WIDTH-1:0] wr_data_0;
  logic                  wr_gnt_0;
  logic                  wr_req_1;
  logic [ADDR_WIDTH-1:0] wr_addr_1;
  logic [DATA_WIDTH-1:0] wr_data_1;
  logic                  wr_gnt_1;

  modport slave (
    input  rd_req_0, rd_addr_0, rd_req_1, rd_addr_1,
    input  wr_req_0, wr_addr_0, wr_data_0, wr_req_1, wr_addr_1, wr_data_1,
    output rd_gnt_0, rd_valid_0, rd_data_0, rd_gnt_1, rd_valid_1, rd_data_1,
    output wr_gnt_0, wr_gnt_1
  );

  modport master (
    output rd_req_0, rd_addr_0, rd_req_1, rd_addr_1,
    output wr_req_0, wr_addr_0, wr_data_0, wr_req_1, wr_addr_1, wr_data_1,
    input  rd_gnt_0, rd_valid_0, rd_data_0, rd_gnt_1, rd_valid_1, rd_data_1,
    input  wr_gnt_0, wr_gnt_1
  );

endinterface

// File: rtl/ext_mem_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter with a 1-bit pointer.
//   clk, arst_n_in : clock, asynchronous active-low reset
//   req[1:0]       : requests
//   gnt[1:0]       : combinational one-hot (or zero) grant
// A lone requester is granted at once; on contention the requester named by
// the pointer wins. After any grant the pointer moves to the other requester.
module rr_arbiter_2
  import ext_mem_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               arst_n_in,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  req_id_t ptr_q, ptr_d;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) ptr_q <= REQ_0;
    else            ptr_q <= ptr_d;
  end

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr_q == REQ_0) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    if (gnt[0])      ptr_d = other_req(REQ_0);
    else if (gnt[1]) ptr_d = other_req(REQ_1);
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// External memory arbiter: two requesters share one read port and one write
// port of a memory with fixed 1-cycle read latency.
//   clk, arst_n_in        : clock, asynchronous active-low reset
//   bus (slave)           : requester read/write handshakes and read returns
//   ext_mem_read_en/addr  : memory read port (driven in the grant cycle)
//   ext_mem_qout          : memory read data, valid one cycle after read_en
//   ext_mem_write_en/addr, ext_mem_din : memory write port
//   rd_cnt_i / wr_cnt_i   : saturating per-requester grant counters
// A same-cycle read and write to one address returns the write data
// (write-first) through a forward field held in the return tag.
`ifndef REG
`define REG(q, d, rv) \
  always_ff @(posedge clk or negedge arst_n_in) \
    if (!arst_n_in) q <= (rv); \
    else q <= (d);
`endif

module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  ext_mem_arbiter_if.slave      bus,
  output logic                  ext_mem_read_en,
  output logic [ADDR_WIDTH-1:0] ext_mem_read_addr,
  input  logic [DATA_WIDTH-1:0] ext_mem_qout,
  output logic                  ext_mem_write_en,
  output logic [ADDR_WIDTH-1:0] ext_mem_write_addr,
  output logic [DATA_WIDTH-1:0] ext_mem_din,
  output logic [CNT_WIDTH-1:0]  rd_cnt_0,
  output logic [CNT_WIDTH-1:0]  rd_cnt_1,
  output logic [CNT_WIDTH-1:0]  wr_cnt_0,
  output logic [CNT_WIDTH-1:0]  wr_cnt_1
);

  logic [NUM_REQ-1:0] rd_req, rd_gnt;
  logic [NUM_REQ-1:0] wr_req, wr_gnt;

  assign rd_req = {bus.rd_req_1, bus.rd_req_0};
  assign wr_req = {bus.wr_req_1, bus.wr_req_0};

  rr_arbiter_2 u_rd_arb (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .req       (rd_req),
    .gnt       (rd_gnt)
  );

  rr_arbiter_2 u_wr_arb (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .req       (wr_req),
    .gnt       (wr_gnt)
  );

  assign bus.rd_gnt_0 = rd_gnt[0];
  assign bus.rd_gnt_1 = rd_gnt[1];
  assign bus.wr_gnt_0 = wr_gnt[0];
  assign bus.wr_gnt_1 = wr_gnt[1];

  // Memory port muxes: zero when idle so the port never shows stale addresses.
  always_comb begin
    ext_mem_read_en   = |rd_gnt;
    ext_mem_read_addr = '0;
    if (rd_gnt[0])      ext_mem_read_addr = bus.rd_addr_0;
    else if (rd_gnt[1]) ext_mem_read_addr = bus.rd_addr_1;
  end

  always_comb begin
    ext_mem_write_en   = |wr_gnt;
    ext_mem_write_addr = '0;
    ext_mem_din        = '0;
    if (wr_gnt[0]) begin
      ext_mem_write_addr = bus.wr_addr_0;
      ext_mem_din        = bus.wr_data_0;
    end else if (wr_gnt[1]) begin
      ext_mem_write_addr = bus.wr_addr_1;
      ext_mem_din        = bus.wr_data_1;
    end
  end

  // Return tag: remembers who was granted the read and, for a same-address
  // write in that cycle, the data that must be returned instead of qout.
  ret_tag_t tag_q, tag_d;
  logic     hazard;

  assign hazard = ext_mem_read_en && ext_mem_write_en &&
                  (ext_mem_read_addr == ext_mem_write_addr);

  always_comb begin
    tag_d          = '0;
    tag_d.valid    = ext_mem_read_en;
    tag_d.id       = rd_gnt[1] ? REQ_1 : REQ_0;
    tag_d.fwd      = hazard;
    tag_d.fwd_data = hazard ? TAG_DATA_WIDTH'(ext_mem_din) : '0;
  end

  `REG(tag_q, tag_d, '0)

  logic [DATA_WIDTH-1:0] ret_data;

  assign ret_data       = tag_q.fwd ? DATA_WIDTH'(tag_q.fwd_data) : ext_mem_qout;
  assign bus.rd_valid_0 = tag_q.valid && (tag_q.id == REQ_0);
  assign bus.rd_valid_1 = tag_q.valid && (tag_q.id == REQ_1);
  assign bus.rd_data_0  = bus.rd_valid_0 ? ret_data : '0;
  assign bus.rd_data_1  = bus.rd_valid_1 ? ret_data : '0;

  // Saturating grant counters, one per channel and requester.
  logic [CNT_WIDTH-1:0] rd_cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0] rd_cnt_d [NUM_REQ];
  logic [CNT_WIDTH-1:0] wr_cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0] wr_cnt_d [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rd_cnt_d[i] = rd_cnt_q[i];
      wr_cnt_d[i] = wr_cnt_q[i];
      if (rd_gnt[i] && (rd_cnt_q[i] != '1)) rd_cnt_d[i] = rd_cnt_q[i] + CNT_WIDTH'(1);
      if (wr_gnt[i] && (wr_cnt_q[i] != '1)) wr_cnt_d[i] = wr_cnt_q[i] + CNT_WIDTH'(1);
    end
  end

  `REG(rd_cnt_q, rd_cnt_d, '{default: '0})
  `REG(wr_cnt_q, wr_cnt_d, '{default: '0})

  assign rd_cnt_0 = rd_cnt_q[0];
  assign rd_cnt_1 = rd_cnt_q[1];
  assign wr_cnt_0 = wr_cnt_q[0];
  assign wr_cnt_1 = wr_cnt_q[1];

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter (CNT_WIDTH=4 so saturation is reachable).
module tb_ext_mem_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic          ext_mem_read_en;
  logic [AW-1:0] ext_mem_read_addr;
  logic [DW-1:0] ext_mem_qout;
  logic          ext_mem_write_en;
  logic [AW-1:0] ext_mem_write_addr;
  logic [DW-1:0] ext_mem_din;
  logic [CW-1:0] rd_cnt_0, rd_cnt_1, wr_cnt_0, wr_cnt_1;

  int checks = 0;
  int errors = 0;

  ext_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ext_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .arst_n_in          (arst_n_in),
    .bus                (bus),
    .ext_mem_read_en    (ext_mem_read_en),
    .ext_mem_read_addr  (ext_mem_read_addr),
    .ext_mem_qout       (ext_mem_qout),
    .ext_mem_write_en   (ext_mem_write_en),
    .ext_mem_write_addr (ext_mem_write_addr),
    .ext_mem_din        (ext_mem_din),
    .rd_cnt_0           (rd_cnt_0),
    .rd_cnt_1           (rd_cnt_1),
    .wr_cnt_0           (wr_cnt_0),
    .wr_cnt_1           (wr_cnt_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_req_0 = 1'b0; bus.rd_addr_0 = '0;
    bus.rd_req_1 = 1'b0; bus.rd_addr_1 = '0;
    bus.wr_req_0 = 1'b0; bus.wr_addr_0 = '0; bus.wr_data_0 = '0;
    bus.wr_req_1 = 1'b0; bus.wr_addr_1 = '0; bus.wr_data_1 = '0;
  endtask

  int gcount;

  initial begin
    idle_inputs();
    ext_mem_qout = '0;
    arst_n_in    = 1'b0;
    #12;
    // Reset state
    check("rst_read_en", ext_mem_read_en, 1'b0);
    check("rst_write_en", ext_mem_write_en, 1'b0);
    check("rst_rd_valid_0", bus.rd_valid_0, 1'b0);
    check("rst_rd_valid_1", bus.rd_valid_1, 1'b0);
    check("rst_cnts", {rd_cnt_0, rd_cnt_1, wr_cnt_0, wr_cnt_1}, 16'h0000);
    arst_n_in = 1'b1;

    // Single read, granted in the first cycle after reset release
    step();
    bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 20'h00010;
    #1;
    check("single_gnt_0", bus.rd_gnt_0, 1'b1);
    check("single_gnt_1", bus.rd_gnt_1, 1'b0);
    check("single_read_en", ext_mem_read_en, 1'b1);
    check("single_read_addr", ext_mem_read_addr, 20'h00010);
    step();
    idle_inputs();
    ext_mem_qout = 32'hDEADBEEF;
    #1;
    check("single_valid_0", bus.rd_valid_0, 1'b1);
    check("single_data_0", bus.rd_data_0, 32'hDEADBEEF);
    check("single_valid_1", bus.rd_valid_1, 1'b0);
    check("single_data_1", bus.rd_data_1, 32'h0);
    check("single_cnt_0", rd_cnt_0, 4'd1);
    step();
    check("single_valid_drop", bus.rd_valid_0, 1'b0);

    // Read contention after reset: grants 0,1,0,1, returns in grant order
    arst_n_in = 1'b0;
    #2;
    check("cont_rst_cnt", rd_cnt_0, 4'd0);
    arst_n_in = 1'b1;
    step();
    bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 20'h00030;
    bus.rd_req_1 = 1'b1; bus.rd_addr_1 = 20'h00040;
    for (int k = 0; k < 4; k++) begin
      ext_mem_qout = 32'h0000_1000 + k;
      #1;
      check($sformatf("cont_gnt0_%0d", k), bus.rd_gnt_0, (k % 2) == 0);
      check($sformatf("cont_gnt1_%0d", k), bus.rd_gnt_1, (k % 2) == 1);
      check($sformatf("cont_addr_%0d", k), ext_mem_read_addr,
            ((k % 2) == 0) ? 20'h00030 : 20'h00040);
      if (k > 0) begin
        check($sformatf("cont_ret_valid_%0d", k),
              ((k % 2) == 1) ? bus.rd_valid_0 : bus.rd_valid_1, 1'b1);
        check($sformatf("cont_ret_data_%0d", k),
              ((k % 2) == 1) ? bus.rd_data_0 : bus.rd_data_1, 32'h0000_1000 + k);
      end
      step();
    end
    idle_inputs();
    ext_mem_qout = 32'h0000_2000;
    #1;
    check("cont_last_valid_1", bus.rd_valid_1, 1'b1);
    check("cont_last_data_1", bus.rd_data_1, 32'h0000_2000);
    check("cont_cnt_0", rd_cnt_0, 4'd2);
    check("cont_cnt_1", rd_cnt_1, 4'd2);

    // Read-after-write hazard: write data is returned, not qout
    step();
    bus.rd_req_1 = 1'b1; bus.rd_addr_1 = 20'h00020;
    bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 20'h00020; bus.wr_data_0 = 32'h12345678;
    #1;
    check("haz_rd_gnt_1", bus.rd_gnt_1, 1'b1);
    check("haz_wr_gnt_0", bus.wr_gnt_0, 1'b1);
    check("haz_write_en", ext_mem_write_en, 1'b1);
    check("haz_write_addr", ext_mem_write_addr, 20'h00020);
    check("haz_din", ext_mem_din, 32'h12345678);
    step();
    idle_inputs();
    ext_mem_qout = 32'hCAFEF00D;
    #1;
    check("haz_valid_1", bus.rd_valid_1, 1'b1);
    check("haz_data_1", bus.rd_data_1, 32'h12345678);
    check("haz_valid_0", bus.rd_valid_0, 1'b0);
    check("haz_wr_cnt_0", wr_cnt_0, 4'd1);

    // Simultaneous read and write by requester 0, different addresses
    step();
    bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 20'h00100;
    bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 20'h00200; bus.wr_data_0 = 32'hA5A5A5A5;
    #1;
    check("sim_rd_gnt_0", bus.rd_gnt_0, 1'b1);
    check("sim_wr_gnt_0", bus.wr_gnt_0, 1'b1);
    check("sim_ports_en", {ext_mem_read_en, ext_mem_write_en}, 2'b11);
    check("sim_read_addr", ext_mem_read_addr, 20'h00100);
    check("sim_write_addr", ext_mem_write_addr, 20'h00200);
    check("sim_din", ext_mem_din, 32'hA5A5A5A5);
    step();
    idle_inputs();
    ext_mem_qout = 32'h55AA55AA;
    #1;
    check("sim_valid_0", bus.rd_valid_0, 1'b1);
    check("sim_data_0", bus.rd_data_0, 32'h55AA55AA);

    // Write contention: last write grant went to 0, so 1 wins first
    step();
    bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 20'h00300; bus.wr_data_0 = 32'h3;
    bus.wr_req_1 = 1'b1; bus.wr_addr_1 = 20'h00400; bus.wr_data_1 = 32'h4;
    #1;
    check("wcont_gnt_1", bus.wr_gnt_1, 1'b1);
    check("wcont_gnt_0_lose", bus.wr_gnt_0, 1'b0);
    check("wcont_addr", ext_mem_write_addr, 20'h00400);
    step();
    check("wcont_gnt_0", bus.wr_gnt_0, 1'b1);
    check("wcont_din", ext_mem_din, 32'h3);
    step();
    idle_inputs();
    #1;
    check("wcont_cnts", {wr_cnt_0, wr_cnt_1}, {4'd3, 4'd1});

    // Saturation: 20 more write grants to requester 1 (already at 1)
    bus.wr_req_1 = 1'b1; bus.wr_addr_1 = 20'h00500; bus.wr_data_1 = 32'h5;
    gcount = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (bus.wr_gnt_1) gcount++;
      step();
    end
    idle_inputs();
    #1;
    check("sat_grants", gcount, 20);
    check("sat_wr_cnt_1", wr_cnt_1, 4'd15);
    check("sat_wr_cnt_0", wr_cnt_0, 4'd3);

    // Reset mid-operation: read granted, reset in the next cycle
    step();
    bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 20'h00600;
    #1;
    check("mid_gnt_0", bus.rd_gnt_0, 1'b1);
    step();
    arst_n_in = 1'b0;
    idle_inputs();
    #1;
    check("mid_valid_0", bus.rd_valid_0, 1'b0);
    check("mid_valid_1", bus.rd_valid_1, 1'b0);
    check("mid_cnts", {rd_cnt_0, rd_cnt_1, wr_cnt_0, wr_cnt_1}, 16'h0000);
    bus.rd_req_0 = 1'b1; bus.rd_req_1 = 1'b1;
    bus.wr_req_0 = 1'b1; bus.wr_req_1 = 1'b1;
    #1;
    check("mid_rd_ptr0", {bus.rd_gnt_1, bus.rd_gnt_0}, 2'b01);
    check("mid_wr_ptr0", {bus.wr_gnt_1, bus.wr_gnt_0}, 2'b01);
    idle_inputs();
    step();
    check("mid_hold_valid", bus.rd_valid_0, 1'b0);
    arst_n_in = 1'b1;
    #1;
    bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 20'h00700;
    bus.rd_req_1 = 1'b1; bus.rd_addr_1 = 20'h00800;
    #1;
    check("post_rst_gnt", {bus.rd_gnt_1, bus.rd_gnt_0}, 2'b01);
    step();
    idle_inputs();
    ext_mem_qout = 32'h0BADF00D;
    #1;
    check("post_rst_valid_0", bus.rd_valid_0, 1'b1);
    check("post_rst_data_0", bus.rd_data_0, 32'h0BADF00D);
    check("post_rst_cnt_0", rd_cnt_0, 4'd1);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_mem_arbiter.md
EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, is the external memory address width ($clog2 of a 1<<20 deep memory).
REQ-002 Parameter DATA_WIDTH, default 32, is the external memory word width (the accumulation width).
REQ-003 Parameter CNT_WIDTH, default 16, is the width of the per-requester grant counters.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk (in, 1) is the clock, and arst_n_in (in, 1) is the asynchronous active-low reset.
REQ-005 For each requester i in {0,1}, the block SHALL provide the following ports:
- rd_req_i (in, 1): read request
- rd_addr_i (in, ADDR_WIDTH): read address
- rd_gnt_i (out, 1): read grant
- rd_valid_i (out, 1): read data valid
- rd_data_i (out, DATA_WIDTH): read data
REQ-006 For each requester i, the block SHALL provide the following ports:
- wr_req_i (in, 1): write request
- wr_addr_i (in, ADDR_WIDTH): write address
- wr_data_i (in, DATA_WIDTH): write data
- wr_gnt_i (out, 1): write grant
REQ-007 The memory-side ports SHALL be:
- ext_mem_read_en (out, 1)
- ext_mem_read_addr (out, ADDR_WIDTH)
- ext_mem_qout (in, DATA_WIDTH)
- ext_mem_write_en (out, 1)
- ext_mem_write_addr (out, ADDR_WIDTH)
- ext_mem_din (out, DATA_WIDTH)
REQ-008 The count ports SHALL be rd_cnt_i and wr_cnt_i (out, CNT_WIDTH): grant counters for requester i.

Function
REQ-009 A transfer occurs in the cycle where req and gnt are both high; the requester SHALL hold req, addr and data stable until gnt.
REQ-010 Read and write SHALL be arbitrated independently, each by its own 1-bit round-robin pointer.
REQ-011 Grants SHALL be combinational from the current requests and the pointer, with at most one rd_gnt and at most one wr_gnt high per cycle.
REQ-012 Grant rules for each channel:
- A single requester SHALL be granted immediately.
- When both requesters request, the one that was not most recently granted on that channel SHALL win.
REQ-013 After each grant, the pointer SHALL update at the clock edge so that the other requester is preferred next; with no grant the pointer SHALL hold.
REQ-014 On a read grant to i: ext_mem_read_en=1 and ext_mem_read_addr=rd_addr_i in the same cycle; otherwise read_en=0 and read_addr=0.
REQ-015 On a write grant to i: ext_mem_write_en=1, ext_mem_write_addr=wr_addr_i and ext_mem_din=wr_data_i in the same cycle; otherwise en/addr/din are 0.
REQ-016 Memory read latency is fixed at 1 cycle.
REQ-017 rd_valid_i SHALL be 1 exactly one cycle after rd_gnt_i, with rd_data_i=ext_mem_qout in that cycle.
REQ-018 The return requester id SHALL be registered (return-tag register); rd_data of a non-returning requester SHALL be 0.
REQ-019 Read-after-write hazard: if the granted read and the granted write share an address in the same cycle, the returned data SHALL be the write data (write-first).
REQ-020 For the hazard case, the forwarded data and a forward flag SHALL be captured in a register.
REQ-021 Back-to-back reads SHALL sustain one grant per cycle, and returns SHALL come back in grant order.
REQ-022 A requester may hold rd_req and wr_req simultaneously; both SHALL be granted in the same cycle if the arbitration on each channel allows.
REQ-023 Counters SHALL increment by 1 per grant of the matching channel and requester, and SHALL saturate at 2^CNT_WIDTH-1 (no wrap).

Reset
REQ-024 Asserting arst_n_in (low) SHALL immediately reset the state:
- both pointers prefer requester 0
- return tag cleared (no rd_valid)
- forward flag and data 0
- all counters 0
REQ-025 A read granted in the cycle before reset asserts SHALL NOT produce rd_valid after reset.
REQ-026 After reset release, the first request SHALL be granted in the same cycle it is presented.

Structure
REQ-027 A shared package SHALL hold the requester-id typedef (1-bit), NUM_REQ=2, and the return-tag struct {valid, id, fwd, fwd_data}.
REQ-028 One sub-module, rr_arbiter_2, SHALL be instantiated twice, once for read and once for write; it contains the pointer and the grant logic.
REQ-029 The counters and the return/forward registers SHALL reside in the top level, and the registers SHALL use the team REG macro.

Verification
REQ-030 The bench SHALL cover a single read:
- Stimulus: rd_req_0, addr 0x00010; memory returns 0xDEADBEEF.
- Required: rd_gnt_0 in the same cycle; next cycle rd_valid_0=1, rd_data_0=0xDEADBEEF, rd_valid_1=0.
REQ-031 The bench SHALL cover read contention:
- Stimulus: both requesters hold rd_req for 4 cycles after reset.
- Required: grants go 0,1,0,1; rd_cnt_0=rd_cnt_1=2.
REQ-032 The bench SHALL cover the hazard case:
- Stimulus: rd_req_1 addr 0x00020 and wr_req_0 addr 0x00020 with data 0x12345678 in the same cycle.
- Required: both granted; next cycle rd_data_1=0x12345678 regardless of ext_mem_qout.
REQ-033 The bench SHALL cover reset mid-operation:
- Stimulus: grant a read, then assert arst_n_in in the next cycle.
- Required: no rd_valid; all counters 0; pointer prefers 0.
REQ-034 The bench SHALL cover counter saturation:
- Stimulus: CNT_WIDTH=4 with 20 consecutive wr grants to requester 1.
- Required: wr_cnt_1=15.
REQ-035 The bench SHALL cover simultaneous read and write by one requester:
- Stimulus: requester 0 holds both rd_req and wr_req, to different addresses.
- Required: both granted the same cycle; the memory write port and read port are driven concurrently.
